// File: rtl/coreaxitoahbl_pkg.sv
// Shared types and constants for the AXI-to-AHB-Lite bridge read path.
// Latency: n/a (declarations only).
// Backpressure: n/a.
package coreaxitoahbl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COLLECT = 2'd1,
    ST_SEND    = 2'd2
  } rd_state_e;

  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

endpackage

// File: rtl/coreaxitoahbl_lane_insert.sv
// Merges a 32-bit LSB-aligned AHB chunk into the AXI assembly word at a lane pointer.
// Latency: purely combinational.
// Backpressure: none; bytes that would land above the top lane are dropped.
module coreaxitoahbl_lane_insert #(
  parameter int AXI_DWIDTH = 64
) (
  input  logic [AXI_DWIDTH-1:0] i_word,
  input  logic [31:0]           i_chunk,
  input  logic [3:0]            i_lane_ptr,
  input  logic [2:0]            i_bytes,
  output logic [AXI_DWIDTH-1:0] o_word
);

  localparam int BPB = AXI_DWIDTH / 8;

  // Byte i of the chunk lands on lane (lane_ptr + i) if that lane exists
  always_comb begin
    o_word = i_word;
    for (int i = 0; i < 4; i++) begin
      if ((i < int'(i_bytes)) && ((int'(i_lane_ptr) + i) < BPB)) begin
        o_word[8*(int'(i_lane_ptr) + i) +: 8] = i_chunk[8*i +: 8];
      end
    end
  end

endmodule

// File: rtl/coreaxitoahbl_rd_data_packer.sv
// Packs narrow AHB read chunks into AXI-width R beats with RLAST/RID/RRESP (COREAXITOAHBL_RD_ERR_EN enables SLVERR reporting).
// Latency: beat valid the cycle after its completing chunk; rdDone the cycle after the last handshake.
// Backpressure: ahbRdReady drops while a beat waits for RREADY; beat fields held stable until accepted.
module coreaxitoahbl_rd_data_packer
  import coreaxitoahbl_pkg::*;
#(
  parameter int AXI_DWIDTH = 64,
  parameter int ID_WIDTH   = 4
) (
  input  logic                  ACLK,
  input  logic                  ARESETN,
  input  logic                  rdStart,
  input  logic [2:0]            addrOffset,
  input  logic [3:0]            burstLen,
  input  logic [7:0]            validBytes,
  input  logic [ID_WIDTH-1:0]   rdId,
  input  logic                  ahbRdValid,
  input  logic [31:0]           ahbRdData,
  input  logic [2:0]            ahbRdBytes,
  input  logic                  ahbRdErr,
  output logic                  ahbRdReady,
  output logic                  RVALID,
  input  logic                  RREADY,
  output logic [AXI_DWIDTH-1:0] RDATA,
  output logic [ID_WIDTH-1:0]   RID,
  output logic [1:0]            RRESP,
  output logic                  RLAST,
  output logic                  rdBusy,
  output logic                  rdDone
);

  localparam int         BPB      = AXI_DWIDTH / 8;
  localparam logic [2:0] OFF_MASK = 3'(BPB - 1);
  localparam logic [3:0] BPB4     = 4'(BPB);

  rd_state_e             r_state, w_state_nxt;
  logic [3:0]            r_lane_ptr, r_beat_cnt, r_off;
  logic [7:0]            r_rem_bytes;
  logic [AXI_DWIDTH-1:0] r_asm, w_asm_merged;
  logic [ID_WIDTH-1:0]   r_id;
  logic                  r_done;
  logic                  w_start, w_accept, w_hs, w_last, w_beat_full;
  logic [3:0]            w_lane_nxt, w_off;
  logic [7:0]            w_rem_nxt, w_bytes8;
  logic [1:0]            w_resp;

  assign w_off       = {1'b0, addrOffset & OFF_MASK};
  assign w_start     = (r_state == ST_IDLE) && rdStart && (validBytes != 8'd0);
  assign w_accept    = (r_state == ST_COLLECT) && ahbRdValid;
  assign w_hs        = (r_state == ST_SEND) && RREADY;
  assign w_last      = (r_beat_cnt == 4'd0) || (r_rem_bytes == 8'd0);
  assign w_bytes8    = {5'b0, ahbRdBytes};
  assign w_lane_nxt  = r_lane_ptr + {1'b0, ahbRdBytes};
  assign w_rem_nxt   = (r_rem_bytes > w_bytes8) ? (r_rem_bytes - w_bytes8) : 8'd0;
  assign w_beat_full = (w_lane_nxt >= BPB4) || (w_rem_nxt == 8'd0);

  coreaxitoahbl_lane_insert #(
    .AXI_DWIDTH(AXI_DWIDTH)
  ) u_lane_insert (
    .i_word    (r_asm),
    .i_chunk   (ahbRdData),
    .i_lane_ptr(r_lane_ptr),
    .i_bytes   (ahbRdBytes),
    .o_word    (w_asm_merged)
  );

  // State register
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) r_state <= ST_IDLE;
    else          r_state <= w_state_nxt;
  end

  // Next-state and R/AHB handshake outputs
  always_comb begin
    w_state_nxt = r_state;
    ahbRdReady  = 1'b0;
    RVALID      = 1'b0;
    RLAST       = 1'b0;
    rdBusy      = (r_state != ST_IDLE);
    rdDone      = r_done;
    RDATA       = r_asm;
    RID         = r_id;
    RRESP       = w_resp;
    case (r_state)
      ST_IDLE: begin
        if (w_start) w_state_nxt = ST_COLLECT;
      end
      ST_COLLECT: begin
        ahbRdReady = 1'b1;
        if (w_accept && w_beat_full) w_state_nxt = ST_SEND;
      end
      ST_SEND: begin
        RVALID = 1'b1;
        RLAST  = w_last;
        if (w_hs) w_state_nxt = w_last ? ST_IDLE : ST_COLLECT;
      end
      default: w_state_nxt = ST_IDLE;
    endcase
  end

  // Burst load, chunk merge and per-beat restart of the assembly word
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN) begin
      r_off       <= '0;
      r_lane_ptr  <= '0;
      r_rem_bytes <= '0;
      r_beat_cnt  <= '0;
      r_asm       <= '0;
      r_id        <= '0;
      r_done      <= 1'b0;
    end else begin
      r_done <= w_hs && w_last;
      if (w_start) begin
        r_off       <= w_off;
        r_lane_ptr  <= w_off;
        r_rem_bytes <= validBytes;
        r_beat_cnt  <= burstLen;
        r_asm       <= '0;
        r_id        <= rdId;
      end else if (w_accept) begin
        r_asm       <= w_asm_merged;
        r_lane_ptr  <= w_lane_nxt;
        r_rem_bytes <= w_rem_nxt;
      end else if (w_hs && !w_last) begin
        r_beat_cnt  <= r_beat_cnt - 4'd1;
        r_lane_ptr  <= r_off;
        r_asm       <= '0;
      end
    end
  end

`ifdef COREAXITOAHBL_RD_ERR_EN
  logic r_err;

  // Sticky error: cleared by a burst load, set by any accepted errored chunk
  always_ff @(posedge ACLK or negedge ARESETN) begin
    if (!ARESETN)                  r_err <= 1'b0;
    else if (w_start)              r_err <= 1'b0;
    else if (w_accept && ahbRdErr) r_err <= 1'b1;
  end

  assign w_resp = r_err ? RESP_SLVERR : RESP_OKAY;
`else
  logic w_unused_err;

  assign w_unused_err = ahbRdErr;
  assign w_resp       = RESP_OKAY;
`endif

endmodule

// File: tb/tb_coreaxitoahbl_rd_data_packer.sv
`timescale 1ns/1ps
module tb_coreaxitoahbl_rd_data_packer;

  typedef struct { logic [31:0] d; int n; bit err; bit ends; } chunk_t;
  typedef struct { logic [63:0] d; logic [1:0] resp; bit last; logic [3:0] id; } beat_t;

  logic ACLK = 0, ARESETN = 0;
  logic rdStart = 0; logic [2:0] addrOffset = 0; logic [3:0] burstLen = 0;
  logic [7:0] validBytes = 0; logic [3:0] rdId = 0;
  logic ahbRdValid = 0; logic [31:0] ahbRdData = 0; logic [2:0] ahbRdBytes = 0; logic ahbRdErr = 0;
  logic ahbRdReady, RVALID, RLAST, rdBusy, rdDone; logic RREADY = 0;
  logic [63:0] RDATA; logic [3:0] RID; logic [1:0] RRESP;
  logic drv_ends = 0;

  logic rdStart32 = 0; logic [2:0] addrOffset32 = 0; logic [3:0] burstLen32 = 0;
  logic [7:0] validBytes32 = 0; logic [3:0] rdId32 = 0;
  logic ahbRdValid32 = 0; logic [31:0] ahbRdData32 = 0; logic [2:0] ahbRdBytes32 = 0;
  logic ahbRdReady32, RVALID32, RLAST32, rdBusy32, rdDone32; logic RREADY32 = 0;
  logic [31:0] RDATA32; logic [3:0] RID32; logic [1:0] RRESP32;

  int total = 0, bad = 0;
  int rr_pct = 100, vld_pct = 100;
  chunk_t drv_q[$], m_chunks[$];
  beat_t  exp_q[$], m_beats[$];

  coreaxitoahbl_rd_data_packer #(.AXI_DWIDTH(64), .ID_WIDTH(4)) u_dut (
    .ACLK(ACLK), .ARESETN(ARESETN), .rdStart(rdStart), .addrOffset(addrOffset),
    .burstLen(burstLen), .validBytes(validBytes), .rdId(rdId), .ahbRdValid(ahbRdValid),
    .ahbRdData(ahbRdData), .ahbRdBytes(ahbRdBytes), .ahbRdErr(ahbRdErr), .ahbRdReady(ahbRdReady),
    .RVALID(RVALID), .RREADY(RREADY), .RDATA(RDATA), .RID(RID), .RRESP(RRESP), .RLAST(RLAST),
    .rdBusy(rdBusy), .rdDone(rdDone));

  coreaxitoahbl_rd_data_packer #(.AXI_DWIDTH(32), .ID_WIDTH(4)) u_dut32 (
    .ACLK(ACLK), .ARESETN(ARESETN), .rdStart(rdStart32), .addrOffset(addrOffset32),
    .burstLen(burstLen32), .validBytes(validBytes32), .rdId(rdId32), .ahbRdValid(ahbRdValid32),
    .ahbRdData(ahbRdData32), .ahbRdBytes(ahbRdBytes32), .ahbRdErr(1'b0), .ahbRdReady(ahbRdReady32),
    .RVALID(RVALID32), .RREADY(RREADY32), .RDATA(RDATA32), .RID(RID32), .RRESP(RRESP32), .RLAST(RLAST32),
    .rdBusy(rdBusy32), .rdDone(rdDone32));

  always #5 ACLK = ~ACLK;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h want %h", name, act, exp);
    end
  endtask

  function automatic chunk_t mk(input logic [31:0] d, input int n, input bit e);
    chunk_t c;
    c.d = d; c.n = n; c.err = e; c.ends = 0;
    return c;
  endfunction

  // Burst-level reference: walk the chunk list, fill lanes from the offset, cut beats
  task automatic run_model(input int bpb, input int aoff, input int blen, input int vb, input bit gen);
    int off, rem, ci; bit err;
    off = aoff % bpb; rem = vb; ci = 0; err = 0;
    m_beats.delete();
    if (gen) m_chunks.delete();
    for (int b = 0; b <= blen; b++) begin
      beat_t bt; int lane; bit full;
      bt.d = '0; bt.id = '0; lane = off; full = 0;
      while (!full) begin
        chunk_t c;
        if (gen) begin
          int n;
          n = 1 << $urandom_range(0, 2);
          while (n > bpb - lane) n = n / 2;
          m_chunks.push_back(mk($urandom, n, $urandom_range(0, 15) == 0));
        end
        if (ci >= m_chunks.size()) begin
          total++; bad++;
          $display("FAIL model_chunks: have=%0d need>%0d", m_chunks.size(), ci);
          return;
        end
        c = m_chunks[ci];
        for (int k = 0; k < c.n; k++)
          if (lane + k < bpb) bt.d[8*(lane+k) +: 8] = c.d[8*k +: 8];
        lane += c.n;
        rem = (rem > c.n) ? rem - c.n : 0;
        if (c.err) err = 1;
        full = (lane >= bpb) || (rem == 0);
        m_chunks[ci].ends = full;
        ci++;
      end
`ifdef COREAXITOAHBL_RD_ERR_EN
      bt.resp = err ? 2'b10 : 2'b00;
`else
      bt.resp = 2'b00;
`endif
      bt.last = (b == blen) || (rem == 0);
      m_beats.push_back(bt);
      if (bt.last) break;
    end
  endtask

  // Chunk source and R-channel sink stimulus, updated 1ns after each rising edge
  initial begin : driver
    bit acc;
    forever begin
      @(negedge ACLK);
      acc = ahbRdValid && ahbRdReady;
      @(posedge ACLK);
      #1;
      if (acc && drv_q.size() > 0) void'(drv_q.pop_front());
      RREADY = ($urandom_range(0, 99) < rr_pct);
      if (drv_q.size() > 0 && $urandom_range(0, 99) < vld_pct) begin
        ahbRdValid = 1; ahbRdData = drv_q[0].d; ahbRdBytes = 3'(drv_q[0].n);
        ahbRdErr = drv_q[0].err; drv_ends = drv_q[0].ends;
      end else begin
        ahbRdValid = 0; ahbRdData = $urandom; ahbRdBytes = 3'($urandom_range(1, 4));
        ahbRdErr = 1'($urandom_range(0, 1)); drv_ends = 0;
      end
    end
  end

  // Compare process: checks R beats, hold-while-stalled, beat boundaries and rdDone
  bit p_acc = 0, p_ends = 0, p_stall = 0, pend_done = 0, p_last = 0;
  logic [63:0] p_d = 0; logic [1:0] p_resp = 0; logic [3:0] p_id = 0;
  always @(negedge ACLK) begin
    if (!ARESETN) begin
      p_acc = 0; p_stall = 0; pend_done = 0;
    end else begin
      if (p_acc) begin
        if (p_ends) chk("beat_after_last_chunk", {RVALID, ahbRdReady}, 2'b10);
        else        chk("still_collecting", {RVALID, ahbRdReady}, 2'b01);
      end
      if (p_stall) begin
        chk("hold_vld", RVALID, 1);
        chk("hold_data", RDATA, p_d);
        chk("hold_ctl", {RLAST, RRESP, RID}, {p_last, p_resp, p_id});
      end
      if (pend_done) chk("rd_done_pulse", rdDone, 1);
      else if (rdDone) begin total++; bad++; $display("FAIL rd_done_spurious: got 1 want 0"); end
      pend_done = 0;
      if (RVALID && RREADY) begin
        if (exp_q.size() == 0) begin
          total++; bad++;
          $display("FAIL unexpected_beat: got data %h want no beat", RDATA);
        end else begin
          beat_t e;
          e = exp_q.pop_front();
          chk("rdata", RDATA, e.d);
          chk("rlast", RLAST, e.last);
          chk("rresp", RRESP, e.resp);
          chk("rid", RID, e.id);
          pend_done = e.last;
        end
      end
      p_acc = ahbRdValid && ahbRdReady; p_ends = drv_ends;
      p_stall = RVALID && !RREADY; p_d = RDATA; p_resp = RRESP; p_last = RLAST; p_id = RID;
    end
  end

  task automatic start_burst(input int off, input int blen, input int vb, input logic [3:0] id);
    int guard = 0;
    while (rdBusy && guard < 3000) begin @(posedge ACLK); #1; guard++; end
    if (rdBusy) begin total++; bad++; $display("FAIL start_wait_idle: busy=1 want 0"); end
    rdStart = 1; addrOffset = 3'(off); burstLen = 4'(blen); validBytes = 8'(vb); rdId = id;
    foreach (m_chunks[i]) drv_q.push_back(m_chunks[i]);
    foreach (m_beats[i]) begin
      beat_t b;
      b = m_beats[i]; b.id = id;
      exp_q.push_back(b);
    end
    @(posedge ACLK); #1;
    rdStart = 0; addrOffset = $urandom; burstLen = $urandom; validBytes = $urandom; rdId = $urandom;
    chk("start_busy_ready", {rdBusy, ahbRdReady}, 2'b11);
  endtask

  task automatic finish_burst();
    int guard = 0;
    while (!(exp_q.size() == 0 && !rdBusy) && guard < 4000) begin
      @(posedge ACLK); #1; guard++;
      rdStart = rdBusy && ($urandom_range(0, 7) == 0);
      if (rdStart) begin validBytes = $urandom; burstLen = $urandom; addrOffset = $urandom; rdId = $urandom; end
    end
    rdStart = 0;
    if (guard >= 4000) begin
      total++; bad++;
      $display("FAIL burst_timeout: beats left=%0d want 0", exp_q.size());
      ARESETN = 0; drv_q.delete(); exp_q.delete();
      @(posedge ACLK); #3 ARESETN = 1;
      @(posedge ACLK); #1;
    end
  endtask

  task automatic wait_rvalid();
    int guard = 0;
    @(negedge ACLK);
    while (!RVALID && guard < 200) begin @(negedge ACLK); guard++; end
    if (!RVALID) begin total++; bad++; $display("FAIL wait_rvalid: got 0 want 1"); end
  endtask

  task automatic load_t1();
    m_chunks.delete();
    m_chunks.push_back(mk(32'h03020100, 4, 0)); m_chunks.push_back(mk(32'h07060504, 4, 0));
    m_chunks.push_back(mk(32'h0B0A0908, 4, 0)); m_chunks.push_back(mk(32'h0F0E0D0C, 4, 0));
    run_model(8, 0, 1, 16, 0);
  endtask

  task automatic load_t2();
    m_chunks.delete();
    m_chunks.push_back(mk(32'h112233AA, 1, 0)); m_chunks.push_back(mk(32'h4455CCBB, 2, 0));
    run_model(8, 5, 0, 3, 0);
  endtask

  initial begin : watchdog
    #900000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin : main
    logic [63:0] held;
    logic [1:0]  exp_resp [4];
    logic [31:0] c32 [3];
    logic [31:0] bd [3];
    logic        bl [3];
    int idx, nb; bit dn, acc;

    repeat (3) @(posedge ACLK);
    @(negedge ACLK);
    chk("rst_ctl", {ahbRdReady, RVALID, RLAST, rdBusy, rdDone}, 0);
    chk("rst_rdata", RDATA, 0);
    chk("rst_rid_rresp", {RID, RRESP}, 0);
    chk("rst_dut32", {ahbRdReady32, RVALID32, rdBusy32, RDATA32}, 0);
    @(posedge ACLK); #3 ARESETN = 1;
    @(posedge ACLK); #1;

    // validBytes of zero must not start a burst
    rdStart = 1; validBytes = 0; burstLen = 3;
    @(posedge ACLK); #1;
    rdStart = 0;
    chk("zero_vb_ignored", {rdBusy, ahbRdReady}, 0);

    // Two full beats from four word chunks
    load_t1();
    chk("model_t1_n", m_beats.size(), 2);
    chk("model_t1_b0", m_beats[0].d, 64'h0706050403020100);
    chk("model_t1_b1", m_beats[1].d, 64'h0F0E0D0C0B0A0908);
    chk("model_t1_last", {m_beats[0].last, m_beats[1].last}, 2'b01);
    start_burst(0, 1, 16, 4'h3); finish_burst();

    // Offset 5, single short beat
    load_t2();
    chk("model_t2", m_beats[0].d, 64'hCCBBAA0000000000);
    chk("model_t2_last", {m_beats.size() == 1, m_beats[0].last}, 2'b11);
    start_burst(5, 0, 3, 4'hA); finish_burst();

    // Stall three cycles in SEND
    rr_pct = 0;
    load_t1();
    start_burst(0, 1, 16, 4'h5);
    wait_rvalid();
    held = RDATA;
    chk("stall_first_beat", held, 64'h0706050403020100);
    for (int k = 0; k < 3; k++) begin
      @(negedge ACLK);
      chk("stall_hold", {RVALID, ahbRdReady, RDATA}, {1'b1, 1'b0, held});
    end
    rr_pct = 100;
    finish_burst();

    // Error on first chunk of beat 2 of 4
    m_chunks.delete();
    for (int k = 0; k < 8; k++) m_chunks.push_back(mk($urandom, 4, k == 2));
    run_model(8, 0, 3, 32, 0);
`ifdef COREAXITOAHBL_RD_ERR_EN
    exp_resp[0] = 2'b00; exp_resp[1] = 2'b10; exp_resp[2] = 2'b10; exp_resp[3] = 2'b10;
`else
    exp_resp[0] = 2'b00; exp_resp[1] = 2'b00; exp_resp[2] = 2'b00; exp_resp[3] = 2'b00;
`endif
    chk("model_err_n", m_beats.size(), 4);
    for (int k = 0; k < 4; k++) chk("model_err_resp", m_beats[k].resp, exp_resp[k]);
    start_burst(0, 3, 32, 4'hE); finish_burst();

    // 32-bit model pin: offset 6 masks to lane 2
    c32[0] = 32'hDEAD1111; c32[1] = 32'hBEEF2222; c32[2] = 32'hCAFE3333;
    m_chunks.delete();
    for (int k = 0; k < 3; k++) m_chunks.push_back(mk(c32[k], 2, 0));
    run_model(4, 6, 2, 6, 0);
    chk("model32_n", m_beats.size(), 3);
    chk("model32_b0", m_beats[0].d, 64'h11110000);
    chk("model32_b2", m_beats[2].d, 64'h33330000);
    chk("model32_last", {m_beats[0].last, m_beats[1].last, m_beats[2].last}, 3'b001);

    // 32-bit instance, same burst
    idx = 0; nb = 0; dn = 0;
    rdStart32 = 1; addrOffset32 = 3'd6; burstLen32 = 4'd2; validBytes32 = 8'd6; rdId32 = 4'h9;
    ahbRdValid32 = 1; ahbRdData32 = c32[0]; ahbRdBytes32 = 3'd2; RREADY32 = 1;
    for (int k = 0; k < 40 && !dn; k++) begin
      @(negedge ACLK);
      acc = ahbRdValid32 && ahbRdReady32;
      if (RVALID32 && RREADY32) begin
        if (nb < 3) begin bd[nb] = RDATA32; bl[nb] = RLAST32; end
        nb++;
      end
      if (rdDone32) dn = 1;
      @(posedge ACLK); #1;
      rdStart32 = 0;
      if (acc) idx++;
      if (idx < 3) ahbRdData32 = c32[idx]; else ahbRdValid32 = 0;
    end
    chk("d32_beats", nb, 3);
    chk("d32_b0", bd[0], 32'h11110000);
    chk("d32_b1", bd[1], 32'h22220000);
    chk("d32_b2", bd[2], 32'h33330000);
    chk("d32_last", {bl[0], bl[1], bl[2]}, 3'b001);
    chk("d32_done_rid", {dn, RID32}, {1'b1, 4'h9});

    // Randomized bursts
    for (int t = 0; t < 100; t++) begin
      int off, blen, vb;
      off = $urandom_range(0, 7); blen = $urandom_range(0, 15);
      vb = ($urandom_range(0, 3) == 0) ? $urandom_range(1, 255) : $urandom_range(1, 40);
      rr_pct = $urandom_range(20, 100); vld_pct = $urandom_range(30, 100);
      run_model(8, off, blen, vb, 1);
      start_burst(off, blen, vb, 4'($urandom));
      finish_burst();
    end
    rr_pct = 100; vld_pct = 100;

    // Asynchronous reset while a beat is waiting
    rr_pct = 0;
    load_t1();
    start_burst(0, 1, 16, 4'h7);
    wait_rvalid();
    @(posedge ACLK); #2;
    ARESETN = 0;
    #1;
    chk("arst_rvalid_busy", {RVALID, rdBusy, ahbRdReady}, 0);
    chk("arst_rdata", RDATA, 0);
    drv_q.delete(); exp_q.delete();
    @(posedge ACLK); #3 ARESETN = 1;
    rr_pct = 100;
    @(posedge ACLK); #1;
    load_t2();
    start_burst(5, 0, 3, 4'h2); finish_burst();

    repeat (3) @(posedge ACLK);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
